ram_16r1w_wr_ctrl: RTL and testbench
====================================

RAM_16R1W_WR_CTRL -- requirements
Module: ram_16r1w_wr_ctrl

Interface
REQ-001 Parameter BLOCKSIZE, default 10, address MSB index; address width AW = BLOCKSIZE+1, depth DEPTH = 2^AW.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 clr_req  input  1  single-cycle request to re-zero the whole array.
REQ-005 a_valid  input  1  requester A write request.
REQ-006 a_addr  input  AW  requester A write address.
REQ-007 a_data  input  32  requester A write data.
REQ-008 a_ready  output  1  requester A accepted this cycle.
REQ-009 b_valid / b_addr / b_data / b_ready: same as REQ-005..008, requester B.
REQ-010 w_addr_1  output  AW  registered write address to the 16-read/1-write RAM.
REQ-011 w_din_1  output  32  registered write data to the RAM.
REQ-012 w_enb_1  output  1  registered write enable to the RAM.
REQ-013 busy  output  1  high while array clear is in progress.
REQ-014 wr_cnt  output  16  count of requester writes issued, saturating.

Function
REQ-015 FSM states: INIT (clearing array) and RUN (serving requesters).
REQ-016 INIT: clear counter clr_ptr steps 0..DEPTH-1, one word per cycle; each cycle registers w_enb_1=1, w_addr_1=clr_ptr, w_din_1=0.
REQ-017 INIT -> RUN on the edge that issues clr_ptr = DEPTH-1; clear takes exactly DEPTH cycles.
REQ-018 busy = 1 whenever state is INIT, 0 in RUN.
REQ-019 a_ready and b_ready are combinational: both 0 unless state = RUN and clr_req = 0.
REQ-020 RUN, only one requester valid: that requester gets ready = 1 in the same cycle.
REQ-021 RUN, both valid: round-robin; requester not granted last gets ready; after reset, A has priority.
REQ-022 Grant-history register updates only on an actual handshake (valid & ready).
REQ-023 Handshake in cycle N: w_enb_1=1, w_addr_1/w_din_1 = granted addr/data in cycle N+1 (one-cycle latency).
REQ-024 RUN, no handshake: w_enb_1=0 next cycle; w_addr_1 and w_din_1 hold previous values.
REQ-025 At most one write per cycle; a_ready & b_ready never both 1.
REQ-026 clr_req=1 in RUN: no grant that cycle; INIT entered next edge with clr_ptr=0; first clear write appears the following cycle.
REQ-027 clr_req=1 in INIT: ignored; clear continues uninterrupted.
REQ-028 wr_cnt increments by 1 per requester handshake and saturates at 16'hFFFF; clear writes not counted; clr_req does not reset wr_cnt.
REQ-029 Requester inputs ignored outside a handshake; valid may drop without being served.

Reset
REQ-030 rst low asynchronously forces state = INIT, clr_ptr = 0, w_enb_1 = 0, w_addr_1 = 0, w_din_1 = 0, wr_cnt = 0, grant history = A-priority, busy = 1.
REQ-031 First clear write (address 0) appears on the first rising edge after rst deasserts.
REQ-032 rst asserted mid-clear or mid-RUN: immediate return to REQ-030 values; clear restarts from 0.

Verification (BLOCKSIZE=3, DEPTH=16)
REQ-033 Release reset, no requests -> 16 consecutive cycles w_enb_1=1, w_addr_1 0..15, w_din_1=0, busy=1; then busy=0, w_enb_1=0.
REQ-034 RUN, A only: a_addr=5, a_data=32'hDEADBEEF -> a_ready=1 same cycle; next cycle w_enb_1=1, w_addr_1=5, w_din_1=32'hDEADBEEF; wr_cnt=1.
REQ-035 RUN, A and B held valid 4 cycles -> grants A,B,A,B; writes appear one cycle later in that order; wr_cnt=4.
REQ-036 RUN, clr_req pulsed while A and B valid -> both ready 0 that cycle; busy=1 next cycle; 16 clear writes; wr_cnt unchanged.
REQ-037 rst asserted at clear address 7 -> outputs zero immediately; after release clear restarts at address 0 with A priority.
REQ-038 Force wr_cnt to 16'hFFFE, issue 3 writes -> wr_cnt reads 16'hFFFF and stays there.

Source files
------------

// File: rtl/ram_16r1w_wr_ctrl.sv
// Write-port controller for a 16-read/1-write RAM.
// Clears the array after reset or on request, then arbitrates two writers.
module ram_16r1w_wr_ctrl #(
  parameter int BLOCKSIZE = 10,
  localparam int AW = BLOCKSIZE + 1,
  localparam int DEPTH = 2 ** AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  input  logic          a_valid,
  input  logic [AW-1:0] a_addr,
  input  logic [31:0]   a_data,
  output logic          a_ready,
  input  logic          b_valid,
  input  logic [AW-1:0] b_addr,
  input  logic [31:0]   b_data,
  output logic          b_ready,
  output logic [AW-1:0] w_addr_1,
  output logic [31:0]   w_din_1,
  output logic          w_enb_1,
  output logic          busy,
  output logic [15:0]   wr_cnt
);

  typedef enum logic {
    INIT = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  state_t        state;
  logic [AW-1:0] clr_ptr;
  logic          last_b;
  logic          open;

  assign busy = (state == INIT);
  assign open = (state == RUN) && !clr_req;

  // Round-robin grant: on contention the side not served last wins.
  always_comb begin
    a_ready = 1'b0;
    b_ready = 1'b0;
    if (open) begin
      a_ready = a_valid && (!b_valid || last_b);
      b_ready = b_valid && (!a_valid || !last_b);
    end
  end

  // Clear sequencing, write-port registers, grant history and write count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= INIT;
      clr_ptr  <= '0;
      last_b   <= 1'b1;
      w_enb_1  <= 1'b0;
      w_addr_1 <= '0;
      w_din_1  <= '0;
      wr_cnt   <= '0;
    end else begin
      unique case (state)
        INIT: begin
          w_enb_1  <= 1'b1;
          w_addr_1 <= clr_ptr;
          w_din_1  <= '0;
          clr_ptr  <= clr_ptr + 1'b1;
          if (clr_ptr == LAST) state <= RUN;
        end
        RUN: begin
          w_enb_1 <= 1'b0;
          if (clr_req) begin
            state   <= INIT;
            clr_ptr <= '0;
          end else if (a_ready || b_ready) begin
            w_enb_1  <= 1'b1;
            w_addr_1 <= a_ready ? a_addr : b_addr;
            w_din_1  <= a_ready ? a_data : b_data;
            last_b   <= b_ready;
            if (wr_cnt != 16'hFFFF) wr_cnt <= wr_cnt + 16'd1;
          end
        end
        default: state <= INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_16r1w_wr_ctrl.sv
// Directed bench for ram_16r1w_wr_ctrl with BLOCKSIZE=3 (16 words).
// Expected values are hand-derived constants.
module tb_ram_16r1w_wr_ctrl;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          clr_req = 1'b0;
  logic          a_valid = 1'b0;
  logic [AW-1:0] a_addr = '0;
  logic [31:0]   a_data = '0;
  logic          a_ready;
  logic          b_valid = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [31:0]   b_data = '0;
  logic          b_ready;
  logic [AW-1:0] w_addr_1;
  logic [31:0]   w_din_1;
  logic          w_enb_1;
  logic          busy;
  logic [15:0]   wr_cnt;

  int passed = 0;
  int total = 0;

  ram_16r1w_wr_ctrl #(.BLOCKSIZE(3)) dut (
    .clk(clk), .rst(rst), .clr_req(clr_req),
    .a_valid(a_valid), .a_addr(a_addr),
    .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_addr(b_addr),
    .b_data(b_data), .b_ready(b_ready),
    .w_addr_1(w_addr_1), .w_din_1(w_din_1),
    .w_enb_1(w_enb_1), .busy(busy),
    .wr_cnt(wr_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h",
                tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_run(input string tag);
    for (int k = 0; k < 16; k++) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_rdy"}, 32'(a_ready | b_ready), 32'd0);
      step();
      chk({tag, "_enb"}, 32'(w_enb_1), 32'd1);
      chk({tag, "_addr"}, 32'(w_addr_1), 32'(k));
      chk({tag, "_din"}, w_din_1, 32'd0);
    end
    chk({tag, "_done"}, 32'(busy), 32'd0);
  endtask

  initial begin
    // Reset state
    #22;
    chk("rst_enb", 32'(w_enb_1), 32'd0);
    chk("rst_addr", 32'(w_addr_1), 32'd0);
    chk("rst_din", w_din_1, 32'd0);
    chk("rst_cnt", 32'(wr_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd1);
    a_valid = 1'b1;
    #1;
    chk("rst_ardy", 32'(a_ready), 32'd0);
    a_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Power-up clear, no requests
    clear_run("clr0");
    step();
    chk("idle_enb", 32'(w_enb_1), 32'd0);

    // A alone
    a_valid = 1'b1;
    a_addr = 4'd5;
    a_data = 32'hDEADBEEF;
    #1;
    chk("a_rdy", 32'(a_ready), 32'd1);
    chk("a_brdy", 32'(b_ready), 32'd0);
    step();
    a_valid = 1'b0;
    chk("a_enb", 32'(w_enb_1), 32'd1);
    chk("a_addr", 32'(w_addr_1), 32'd5);
    chk("a_din", w_din_1, 32'hDEADBEEF);
    chk("a_cnt", 32'(wr_cnt), 32'd1);
    step();
    chk("hold_enb", 32'(w_enb_1), 32'd0);
    chk("hold_addr", 32'(w_addr_1), 32'd5);
    chk("hold_din", w_din_1, 32'hDEADBEEF);

    // B alone; history now points at A next
    b_valid = 1'b1;
    b_addr = 4'd9;
    b_data = 32'h12345678;
    #1;
    chk("b_rdy", 32'(b_ready), 32'd1);
    chk("b_ardy", 32'(a_ready), 32'd0);
    step();
    b_valid = 1'b0;
    chk("b_addr", 32'(w_addr_1), 32'd9);
    chk("b_din", w_din_1, 32'h12345678);
    chk("b_cnt", 32'(wr_cnt), 32'd2);

    // Contention: A,B,A,B
    a_valid = 1'b1;
    a_addr = 4'd1;
    a_data = 32'hA1;
    b_valid = 1'b1;
    b_addr = 4'd2;
    b_data = 32'hB2;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("rr_ardy", 32'(a_ready), (i % 2 == 0) ? 32'd1 : 32'd0);
      chk("rr_brdy", 32'(b_ready), (i % 2 == 0) ? 32'd0 : 32'd1);
      step();
      chk("rr_enb", 32'(w_enb_1), 32'd1);
      chk("rr_addr", 32'(w_addr_1), (i % 2 == 0) ? 32'd1 : 32'd2);
      chk("rr_din", w_din_1, (i % 2 == 0) ? 32'hA1 : 32'hB2);
    end
    chk("rr_cnt", 32'(wr_cnt), 32'd6);

    // Clear request with both requesters pending
    clr_req = 1'b1;
    #1;
    chk("cq_ardy", 32'(a_ready), 32'd0);
    chk("cq_brdy", 32'(b_ready), 32'd0);
    step();
    clr_req = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    chk("cq_busy", 32'(busy), 32'd1);
    chk("cq_enb", 32'(w_enb_1), 32'd0);
    // A second clear request mid-clear must not disturb it
    clr_req = 1'b1;
    step();
    step();
    clr_req = 1'b0;
    chk("cq_mid_addr", 32'(w_addr_1), 32'd1);
    for (int k = 2; k < 16; k++) step();
    chk("cq_end_addr", 32'(w_addr_1), 32'd15);
    chk("cq_end_busy", 32'(busy), 32'd0);
    chk("cq_cnt", 32'(wr_cnt), 32'd6);

    // Reset in the middle of a clear
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    for (int k = 0; k < 8; k++) step();
    chk("mr_pre_addr", 32'(w_addr_1), 32'd7);
    rst = 1'b0;
    #1;
    chk("mr_enb", 32'(w_enb_1), 32'd0);
    chk("mr_addr", 32'(w_addr_1), 32'd0);
    chk("mr_cnt", 32'(wr_cnt), 32'd0);
    chk("mr_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b1;
    clear_run("clr1");
    a_valid = 1'b1;
    b_valid = 1'b1;
    #1;
    chk("pri_ardy", 32'(a_ready), 32'd1);
    chk("pri_brdy", 32'(b_ready), 32'd0);
    b_valid = 1'b0;
    step();
    chk("pri_cnt", 32'(wr_cnt), 32'd1);

    // Saturation: run the count up to FFFE, then 3 more
    for (int i = 0; i < 65533; i++) step();
    chk("sat_fffe", 32'(wr_cnt), 32'h0000FFFE);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("sat_ffff", 32'(wr_cnt), 32'h0000FFFF);
    end
    a_valid = 1'b0;
    step();
    chk("sat_hold", 32'(wr_cnt), 32'h0000FFFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
